port_match_sequencer: RTL and testbench

- Controller that sequences one port_comparator instance across a stream of packets.
- Per packet: applies the configured port, pulses the comparator clear, streams 32-bit words in, drains the comparator pipeline, then issues a one-cycle verdict.
- Sits between the packet word stream (upstream of the comparator) and the alert/statistics logic (downstream).

---
 rtl/eth_sniffer_pkg.sv | 17 +
 rtl/sat_counter.sv | 19 +
 rtl/port_match_sequencer.sv | 166 ++++++++++++++++
 tb/tb_port_match_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_sniffer_pkg.sv
// Shared types and widths for the packet sniffer datapath.
package eth_sniffer_pkg;

   localparam int unsigned PORT_W       = 16;
   localparam int unsigned WORD_W       = 32;
   localparam int unsigned CMP_PIPE_LAT = 3;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      DRAIN,
      REPORT,
      DISCARD
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/port_match_sequencer.sv
// Sequences one external port comparator across a packet stream and
// reports a per-packet verdict plus saturating match statistics.
module port_match_sequencer
   import eth_sniffer_pkg::*;
#(
   parameter int unsigned PIPE_LAT  = CMP_PIPE_LAT,
   parameter int unsigned MAX_WORDS = 380,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic [PORT_W-1:0] cfg_port,
   input  logic              pkt_valid,
   input  logic              pkt_sop,
   input  logic              pkt_eop,
   input  logic [WORD_W-1:0] pkt_data,
   output logic              pkt_ready,
   output logic              cmp_clear,
   output logic [PORT_W-1:0] cmp_flagged_port,
   output logic [WORD_W-1:0] cmp_data_in,
   input  logic              cmp_match,
   output logic              verdict_valid,
   output logic              verdict_match,
   output logic              verdict_err,
   output logic [CNT_W-1:0]  match_count,
   output logic [CNT_W-1:0]  pkt_count
);

   localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);
   localparam int unsigned DCNT_W = $clog2(PIPE_LAT + 1);

   state_t              state;
   state_t              state_nxt;
   logic [PORT_W-1:0]   shadow;
   logic [WCNT_W-1:0]   word_cnt;
   logic [DCNT_W-1:0]   drain_cnt;
   logic                hit;
   logic                err;
   logic                oversize;
   logic                ready;
   logic                accept;
   logic                sop_abort;
   logic                first_word;
   logic                last_word;
   logic                drain_done;

   // The sop word that opened the packet is accepted as its first word;
   // a sop seen after that marks a truncated packet.
   assign first_word = (word_cnt == '0);
   assign last_word  = (word_cnt == WCNT_W'(MAX_WORDS - 1));
   assign drain_done = (drain_cnt == DCNT_W'(PIPE_LAT - 1));
   assign accept     = pkt_valid & ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      sop_abort = 1'b0;
      case (state)
         IDLE: begin
            ready = ~pkt_sop;
            if (pkt_valid && pkt_sop) state_nxt = CLEAR;
         end
         CLEAR: begin
            state_nxt = STREAM;
         end
         STREAM: begin
            ready = ~pkt_sop | first_word;
            if (pkt_valid && pkt_sop && !first_word) begin
               sop_abort = 1'b1;
               state_nxt = DRAIN;
            end else if (pkt_valid && (pkt_eop || last_word)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_done) state_nxt = REPORT;
         end
         REPORT: begin
            state_nxt = oversize ? DISCARD : IDLE;
         end
         DISCARD: begin
            ready = ~pkt_sop;
            if (pkt_valid && pkt_sop) begin
               state_nxt = CLEAR;
            end else if (pkt_valid && pkt_eop) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Per-packet context: shadow port, word/drain counters, sticky hit and error.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow           <= '0;
         cmp_flagged_port <= '0;
         word_cnt         <= '0;
         drain_cnt        <= '0;
         hit              <= 1'b0;
         err              <= 1'b0;
         oversize         <= 1'b0;
      end else begin
         if (cfg_wr) shadow <= cfg_port;
         case (state)
            CLEAR: begin
               cmp_flagged_port <= shadow;
               word_cnt         <= '0;
               drain_cnt        <= '0;
               hit              <= 1'b0;
               err              <= 1'b0;
               oversize         <= 1'b0;
            end
            STREAM: begin
               hit <= hit | cmp_match;
               if (accept) word_cnt <= word_cnt + WCNT_W'(1);
               if (sop_abort) begin
                  err <= 1'b1;
               end else if (accept && !pkt_eop && last_word) begin
                  err      <= 1'b1;
                  oversize <= 1'b1;
               end
            end
            DRAIN: begin
               hit       <= hit | cmp_match;
               drain_cnt <= drain_cnt + DCNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign pkt_ready     = ready & ~rst;
   assign cmp_clear     = (state == CLEAR);
   assign cmp_data_in   = ((state == STREAM) && accept) ? pkt_data : '0;
   assign verdict_valid = (state == REPORT);
   assign verdict_match = verdict_valid & hit & (cmp_flagged_port != '0);
   assign verdict_err   = verdict_valid & err;

   sat_counter #(.CNT_W(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (verdict_valid),
      .count (pkt_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (verdict_match),
      .count (match_count)
   );

endmodule

// File: tb/tb_port_match_sequencer.sv
// Directed bench for port_match_sequencer with a small word limit and narrow counters.
module tb_port_match_sequencer;
   import eth_sniffer_pkg::*;

   localparam int unsigned PL = 3;
   localparam int unsigned MW = 4;
   localparam int unsigned CW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_wr;
   logic [15:0]       cfg_port;
   logic              pkt_valid;
   logic              pkt_sop;
   logic              pkt_eop;
   logic [31:0]       pkt_data;
   logic              pkt_ready;
   logic              cmp_clear;
   logic [15:0]       cmp_flagged_port;
   logic [31:0]       cmp_data_in;
   logic              cmp_match;
   logic              verdict_valid;
   logic              verdict_match;
   logic              verdict_err;
   logic [CW-1:0]     match_count;
   logic [CW-1:0]     pkt_count;

   always #5 clk = ~clk;

   port_match_sequencer #(.PIPE_LAT(PL), .MAX_WORDS(MW), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_wr           (cfg_wr),
      .cfg_port         (cfg_port),
      .pkt_valid        (pkt_valid),
      .pkt_sop          (pkt_sop),
      .pkt_eop          (pkt_eop),
      .pkt_data         (pkt_data),
      .pkt_ready        (pkt_ready),
      .cmp_clear        (cmp_clear),
      .cmp_flagged_port (cmp_flagged_port),
      .cmp_data_in      (cmp_data_in),
      .cmp_match        (cmp_match),
      .verdict_valid    (verdict_valid),
      .verdict_match    (verdict_match),
      .verdict_err      (verdict_err),
      .match_count      (match_count),
      .pkt_count        (pkt_count)
   );

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   vcnt = 0;
   int   v_cyc = -1;
   int   clr_cyc = -1;
   int   zero_viol = 0;
   logic v_match = 1'b0;
   logic v_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Records clear pulses and verdict strobes as they happen.
   always @(negedge clk) begin
      if (cmp_clear) clr_cyc <= cyc;
      if (verdict_valid) begin
         vcnt    <= vcnt + 1;
         v_cyc   <= cyc;
         v_match <= verdict_match;
         v_err   <= verdict_err;
      end else if (verdict_match || verdict_err) begin
         zero_viol <= zero_viol + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [15:0] p);
      cfg_wr   = 1'b1;
      cfg_port = p;
      step();
      cfg_wr   = 1'b0;
      cfg_port = 16'h0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Presents one word until it is accepted; returns handshake cycle and comparator word.
   task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                            output int hs, output logic [31:0] seen);
      pkt_valid = 1'b1;
      pkt_data  = d;
      pkt_sop   = sop;
      pkt_eop   = eop;
      hs        = -1;
      seen      = 32'h0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pkt_ready) begin
            hs   = cyc;
            seen = cmp_data_in;
         end
         step();
         if (hs >= 0) break;
      end
      pkt_valid = 1'b0;
      pkt_sop   = 1'b0;
      pkt_eop   = 1'b0;
      pkt_data  = 32'h0;
      if (hs < 0) chk("handshake_timeout", 32'(hs), 32'h0);
   endtask

   task automatic wait_verdict();
      int start;
      start = vcnt;
      for (int i = 0; i < 30; i++) begin
         if (vcnt > start) break;
         step();
      end
      chk("verdict_arrived", 32'(vcnt > start), 32'h1);
   endtask

   typedef struct {
      logic        do_rst;
      logic        do_cfg;
      logic [15:0] cfg;
      logic        mid_cfg;
      logic [15:0] mid_val;
      int          nw;
      logic        match_in;
      logic        exp_match;
      logic        exp_err;
      logic [15:0] exp_flag;
      logic [1:0]  exp_mc;
      logic [1:0]  exp_pc;
   } vec_t;

   vec_t        tbl [9];
   int          hs;
   int          hs_b;
   int          v0;
   logic [31:0] seen;
   logic [31:0] d;

   initial begin
      tbl[0] = '{1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000, 2, 1'b1, 1'b1, 1'b0, 16'hABCD, 2'd1, 2'd1};
      tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 2, 1'b1, 1'b1, 1'b0, 16'hABCD, 2'd2, 2'd2};
      tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2, 1'b0, 1'b0, 1'b0, 16'h1234, 2'd2, 2'd3};
      tbl[3] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 2, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 2'd1};
      tbl[4] = '{1'b0, 1'b1, 16'h0055, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 1'b0, 16'h0055, 2'd1, 2'd2};
      tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4, 1'b1, 1'b1, 1'b0, 16'h0055, 2'd2, 2'd3};
      tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2, 1'b1, 1'b1, 1'b0, 16'h0055, 2'd3, 2'd3};
      tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b1, 1'b1, 1'b0, 16'h0055, 2'd3, 2'd3};
      tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 2, 1'b1, 1'b1, 1'b0, 16'h0055, 2'd3, 2'd3};

      rst       = 1'b1;
      cfg_wr    = 1'b0;
      cfg_port  = 16'h0;
      pkt_valid = 1'b0;
      pkt_sop   = 1'b0;
      pkt_eop   = 1'b0;
      pkt_data  = 32'h0;
      cmp_match = 1'b0;

      // Reset state
      step();
      step();
      @(negedge clk);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      chk("rst_ready", 32'(pkt_ready), 32'h0);
      chk("rst_clear", 32'(cmp_clear), 32'h0);
      chk("rst_flag", 32'(cmp_flagged_port), 32'h0);
      chk("rst_data", cmp_data_in, 32'h0);
      chk("rst_vvalid", 32'(verdict_valid), 32'h0);
      chk("rst_mcount", 32'(match_count), 32'h0);
      chk("rst_pcount", 32'(pkt_count), 32'h0);
      step();
      rst = 1'b0;
      write_cfg(16'hABCD);
      step();
      step();
      @(negedge clk);
      chk("cfg_not_applied_in_idle", 32'(cmp_flagged_port), 32'h0);
      chk("idle_ready", 32'(pkt_ready), 32'h1);
      step();

      // Table of whole packets
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].do_rst) pulse_rst();
         if (tbl[i].do_cfg) write_cfg(tbl[i].cfg);
         for (int w = 0; w < tbl[i].nw; w++) begin
            d = {8'hA5, 8'(i), 8'h00, 8'(w + 1)};
            send_word(d, w == 0, w == tbl[i].nw - 1, hs, seen);
            chk($sformatf("v%0d_w%0d_data", i, w), seen, d);
            if (w == 0) chk($sformatf("v%0d_clear_lead", i), 32'(hs - clr_cyc), 32'h1);
            if (w == 0 && tbl[i].mid_cfg) write_cfg(tbl[i].mid_val);
         end
         cmp_match = tbl[i].match_in;
         wait_verdict();
         cmp_match = 1'b0;
         chk($sformatf("v%0d_latency", i), 32'(v_cyc - hs), 32'(PL + 1));
         chk($sformatf("v%0d_match", i), 32'(v_match), 32'(tbl[i].exp_match));
         chk($sformatf("v%0d_err", i), 32'(v_err), 32'(tbl[i].exp_err));
         chk($sformatf("v%0d_flag", i), 32'(cmp_flagged_port), 32'(tbl[i].exp_flag));
         chk($sformatf("v%0d_mcount", i), 32'(match_count), 32'(tbl[i].exp_mc));
         chk($sformatf("v%0d_pcount", i), 32'(pkt_count), 32'(tbl[i].exp_pc));
      end

      // Oversize: six words against a four-word limit, then a clean packet
      pulse_rst();
      write_cfg(16'hABCD);
      v0 = vcnt;
      for (int w = 0; w < 4; w++) begin
         d = {8'hB0, 8'h00, 8'h00, 8'(w + 1)};
         send_word(d, w == 0, 1'b0, hs, seen);
         chk($sformatf("ovs_w%0d_data", w), seen, d);
      end
      wait_verdict();
      chk("ovs_err", 32'(v_err), 32'h1);
      chk("ovs_match", 32'(v_match), 32'h0);
      chk("ovs_latency", 32'(v_cyc - hs), 32'(PL + 1));
      send_word(32'hB0000005, 1'b0, 1'b0, hs_b, seen);
      chk("ovs_discard_ready", 32'(hs_b - v_cyc), 32'h1);
      chk("ovs_w5_dropped", seen, 32'h0);
      send_word(32'hB0000006, 1'b0, 1'b1, hs_b, seen);
      chk("ovs_w6_dropped", seen, 32'h0);
      send_word(32'hC0000001, 1'b1, 1'b1, hs, seen);
      chk("ovs_next_data", seen, 32'hC0000001);
      chk("ovs_next_clear_lead", 32'(hs - clr_cyc), 32'h1);
      cmp_match = 1'b1;
      wait_verdict();
      cmp_match = 1'b0;
      chk("ovs_next_err", 32'(v_err), 32'h0);
      chk("ovs_next_match", 32'(v_match), 32'h1);
      chk("ovs_verdicts", 32'(vcnt - v0), 32'h2);
      chk("ovs_pcount", 32'(pkt_count), 32'h2);
      chk("ovs_mcount", 32'(match_count), 32'h1);

      // Truncation: sop arrives before eop
      pulse_rst();
      write_cfg(16'hABCD);
      v0 = vcnt;
      send_word(32'hD0000001, 1'b1, 1'b0, hs, seen);
      send_word(32'hD0000002, 1'b0, 1'b0, hs, seen);
      send_word(32'hE0000001, 1'b1, 1'b1, hs, seen);
      chk("trn_verdicts", 32'(vcnt - v0), 32'h1);
      chk("trn_err", 32'(v_err), 32'h1);
      chk("trn_verdict_before_clear", 32'(v_cyc < clr_cyc), 32'h1);
      chk("trn_clear_lead", 32'(hs - clr_cyc), 32'h1);
      chk("trn_new_data", seen, 32'hE0000001);
      wait_verdict();
      chk("trn_new_err", 32'(v_err), 32'h0);
      chk("trn_pcount", 32'(pkt_count), 32'h2);

      // Reset mid-packet abandons it without a verdict
      v0 = vcnt;
      send_word(32'hF0000001, 1'b1, 1'b0, hs, seen);
      send_word(32'hF0000002, 1'b0, 1'b0, hs, seen);
      pulse_rst();
      for (int i = 0; i < 8; i++) step();
      chk("mid_rst_no_verdict", 32'(vcnt - v0), 32'h0);
      chk("mid_rst_pcount", 32'(pkt_count), 32'h0);
      send_word(32'hF1000001, 1'b1, 1'b1, hs, seen);
      chk("mid_rst_clear_lead", 32'(hs - clr_cyc), 32'h1);
      wait_verdict();
      chk("mid_rst_err", 32'(v_err), 32'h0);
      chk("mid_rst_pcount_after", 32'(pkt_count), 32'h1);

      chk("verdict_fields_idle_zero", 32'(zero_viol), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
